depthwise_rom_sequencer: RTL

//  Sequences reads from the depthwise input-row ROM (channel x row x file, combinational read) and streams them
//  to the systolic array as a valid/ready stream with channel/row/file tags. Run size set per job via start + cfg.

---
 rtl/depthwise_pkg.sv | 34 +++
 rtl/nested_index_counter.sv | 70 +++++++
 rtl/depthwise_rom_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/depthwise_pkg.sv
// Shared definitions for the depthwise ROM sequencer.
//   CH_AW / ROW_AW / FILE_AW : index widths of the ROM address fields
//   W                        : ROM / beat data width
//   state_e                  : sequencer FSM states
//   beat_t                   : contents of the output beat register
//   cfg_field_bad()          : a job size field of zero or above its limit is rejected
package depthwise_pkg;

  localparam int CH_AW   = 4;
  localparam int ROW_AW  = 14;
  localparam int FILE_AW = 4;
  localparam int W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [W-1:0]       data;
    logic [CH_AW-1:0]   ch;
    logic [ROW_AW-1:0]  row;
    logic [FILE_AW-1:0] file;
    logic               last_file;
    logic               last;
  } beat_t;

  function automatic logic cfg_field_bad(input int unsigned val, input int unsigned max_val);
    return (val == 0) || (val > max_val);
  endfunction

endpackage

// File: rtl/nested_index_counter.sv
// Three-level wrap counter walking channel (outer), row, file (inner).
//   clk, rst_n        : clock, async active-low reset
//   i_clear           : synchronous return of all indices to 0
//   i_inc             : advance by one position
//   i_lim_ch/row/file : sweep sizes (count of positions per level, >= 1)
//   o_ch/o_row/o_file : current indices
//   o_file_wrap       : file index is at its last position
//   o_last            : all three indices at their last positions
// The caller never increments while o_last is high, so indices stay below
// their limits; the channel wrap to 0 only guards against misuse.
module nested_index_counter
  import depthwise_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_inc,
  input  logic [CH_AW:0]     i_lim_ch,
  input  logic [ROW_AW:0]    i_lim_row,
  input  logic [FILE_AW:0]   i_lim_file,
  output logic [CH_AW-1:0]   o_ch,
  output logic [ROW_AW-1:0]  o_row,
  output logic [FILE_AW-1:0] o_file,
  output logic               o_file_wrap,
  output logic               o_last
);

  logic [CH_AW-1:0]   r_ch;
  logic [ROW_AW-1:0]  r_row;
  logic [FILE_AW-1:0] r_file;
  logic               w_ch_wrap;
  logic               w_row_wrap;
  logic               w_file_wrap;

  // index + 1 == limit, evaluated one bit wider so a limit of 2^AW works
  assign w_ch_wrap   = ({1'b0, r_ch}   + (CH_AW+1)'(1))   == i_lim_ch;
  assign w_row_wrap  = ({1'b0, r_row}  + (ROW_AW+1)'(1))  == i_lim_row;
  assign w_file_wrap = ({1'b0, r_file} + (FILE_AW+1)'(1)) == i_lim_file;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch   <= '0;
      r_row  <= '0;
      r_file <= '0;
    end else if (i_clear) begin
      r_ch   <= '0;
      r_row  <= '0;
      r_file <= '0;
    end else if (i_inc) begin
      if (w_file_wrap) begin
        r_file <= '0;
        if (w_row_wrap) begin
          r_row <= '0;
          r_ch  <= w_ch_wrap ? '0 : r_ch + CH_AW'(1);
        end else begin
          r_row <= r_row + ROW_AW'(1);
        end
      end else begin
        r_file <= r_file + FILE_AW'(1);
      end
    end
  end

  assign o_ch        = r_ch;
  assign o_row       = r_row;
  assign o_file      = r_file;
  assign o_file_wrap = w_file_wrap;
  assign o_last      = w_ch_wrap & w_row_wrap & w_file_wrap;

endmodule

// File: rtl/depthwise_rom_sequencer.sv
// Walks the depthwise input-row ROM (channel x row x file) and streams each
// word to the systolic array as a valid/ready beat with its tags.
//   clk, rst_n                  : clock, async active-low reset
//   i_start, i_cfg_*            : job start pulse and sweep sizes (taken in IDLE)
//   i_abort                     : cancel the running job
//   o_busy, o_done, o_cfg_err   : job status (done is a 1-cycle pulse)
//   o_rom_ch/row/file, i_rom_data : ROM address out, combinational data back
//   o_out_* / i_out_ready       : output beat stream
//
// state | meaning
// IDLE  | waiting for start
// RUN   | loading ROM words into the output register
// DRAIN | last address loaded, waiting for the final beat to be taken
// DONE  | one cycle, done pulse high
module depthwise_rom_sequencer
  import depthwise_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned ROWS         = 12544,
  parameter int unsigned NUM_FILES    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [CH_AW:0]     i_cfg_channels,
  input  logic [ROW_AW:0]    i_cfg_rows,
  input  logic [FILE_AW:0]   i_cfg_files,
  input  logic               i_abort,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_cfg_err,
  output logic [CH_AW-1:0]   o_rom_ch,
  output logic [ROW_AW-1:0]  o_rom_row,
  output logic [FILE_AW-1:0] o_rom_file,
  input  logic [W-1:0]       i_rom_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [W-1:0]       o_out_data,
  output logic [CH_AW-1:0]   o_out_ch,
  output logic [ROW_AW-1:0]  o_out_row,
  output logic [FILE_AW-1:0] o_out_file,
  output logic               o_out_last_file,
  output logic               o_out_last
);

  state_e             r_state;
  logic [CH_AW:0]     r_lim_ch;
  logic [ROW_AW:0]    r_lim_row;
  logic [FILE_AW:0]   r_lim_file;
  beat_t              r_beat;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_err;

  logic               w_cfg_bad;
  logic               w_load;
  logic               w_clear;
  logic               w_inc;
  logic [CH_AW-1:0]   w_ch;
  logic [ROW_AW-1:0]  w_row;
  logic [FILE_AW-1:0] w_file;
  logic               w_file_wrap;
  logic               w_idx_last;

  assign w_cfg_bad = cfg_field_bad(32'(i_cfg_channels), NUM_CHANNELS) ||
                     cfg_field_bad(32'(i_cfg_rows), ROWS) ||
                     cfg_field_bad(32'(i_cfg_files), NUM_FILES);

  // abort outranks a load so a cancelled job never emits another beat
  assign w_load  = (r_state == RUN) && !i_abort && (!r_valid || i_out_ready);
  assign w_clear = (r_state == IDLE) && i_start;
  // the final address is loaded without advancing, keeping rom_* in range
  assign w_inc   = w_load && !w_idx_last;

  nested_index_counter u_idx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_inc       (w_inc),
    .i_lim_ch    (r_lim_ch),
    .i_lim_row   (r_lim_row),
    .i_lim_file  (r_lim_file),
    .o_ch        (w_ch),
    .o_row       (w_row),
    .o_file      (w_file),
    .o_file_wrap (w_file_wrap),
    .o_last      (w_idx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lim_ch   <= '0;
      r_lim_row  <= '0;
      r_lim_file <= '0;
      r_beat     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_lim_ch   <= i_cfg_channels;
            r_lim_row  <= i_cfg_rows;
            r_lim_file <= i_cfg_files;
            r_cfg_err  <= w_cfg_bad;
            if (w_cfg_bad) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (i_abort) begin
            r_valid <= 1'b0;
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_load) begin
            r_beat.data      <= i_rom_data;
            r_beat.ch        <= w_ch;
            r_beat.row       <= w_row;
            r_beat.file      <= w_file;
            r_beat.last_file <= w_file_wrap;
            r_beat.last      <= w_idx_last;
            r_valid          <= 1'b1;
            if (w_idx_last) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (i_abort || (r_valid && i_out_ready)) begin
            r_valid <= 1'b0;
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_cfg_err       = r_cfg_err;
  assign o_rom_ch        = w_ch;
  assign o_rom_row       = w_row;
  assign o_rom_file      = w_file;
  assign o_out_valid     = r_valid;
  assign o_out_data      = r_beat.data;
  assign o_out_ch        = r_beat.ch;
  assign o_out_row       = r_beat.row;
  assign o_out_file      = r_beat.file;
  assign o_out_last_file = r_beat.last_file;
  assign o_out_last      = r_beat.last;

endmodule
